angle_range_reducer: RTL and testbench
======================================

Name: angle_range_reducer

Overview:
- Front end of the sine/cosine path: takes an arbitrary signed fixed-point angle θ and finds integer k and residual r with θ = r + k·π/2 and r ∈ [−π/4, +π/4].
- r feeds the CORDIC core; the 3-bit flip code feeds the downstream flip/result correction stage.
- Multi-cycle iterative shift-subtract divider with valid/ready handshakes on both sides.

Parameters:
- IN_WIDTH, 20, width of input angle, signed, FRAC fractional bits.
- WIDTH, 16, width of output residual, signed Q2.FRAC, matches CORDIC data width.
- FRAC, 13, fractional bits of both input and output.
- HALF_PI, 12868, round(π/2·2^FRAC). QUARTER_PI is derived as HALF_PI>>1 (6434).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  angle_in valid.
- in_ready  out  1  block can accept an angle.
- angle_in  in  IN_WIDTH  signed angle θ.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- angle_out  out  WIDTH  signed residual r.
- flip  out  3  quadrant code for the flip/result correction stage.

Behaviour:
- Local constant Q_BITS = IN_WIDTH−FRAC (7 by default), which is the number of quotient bits.
- States: IDLE, DIVIDE, ADJUST, DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- Reset (async, rst_n=0):
  - state=IDLE, angle_out=0, flip=3'b000, out_valid=0.
  - Internal rem, q, sign and iteration counter are all cleared.
- IDLE: on in_valid&in_ready, latch sign=angle_in[MSB] and mag=|angle_in| in IN_WIDTH+1 bits, so −2^(IN_WIDTH−1) does not overflow. Set q=0, i=Q_BITS−1, then go to DIVIDE.
- DIVIDE, one quotient bit per cycle:
  - If rem ≥ HALF_PI<<i, then rem −= HALF_PI<<i and q[i]=1.
  - After i=0 go to ADJUST. Exactly Q_BITS cycles.
- ADJUST, one cycle:
  - If rem > QUARTER_PI, then rem −= HALF_PI and q += 1. rem == QUARTER_PI is not adjusted.
  - If sign, then r=−rem and k=−q; otherwise r=rem and k=q.
  - Register angle_out=r[WIDTH−1:0] and flip from k mod 4: 0→3'b000, 1→3'b101, 2→3'b010, 3→3'b001. 3'b100 is never produced.
  - Go to DONE.
- Latency: out_valid rises Q_BITS+2 rising edges after the input handshake edge (9 by default). Throughput is one angle per Q_BITS+3 cycles minimum.
- DONE:
  - angle_out and flip are held stable while out_ready=0.
  - On out_ready=1: go to IDLE, deassert out_valid, and keep angle_out and flip at their last values.
  - The next input can be accepted in the cycle after.
- angle_in changing while in_ready=0 is ignored.
- rst_n asserted mid-operation aborts immediately to reset values. No partial result is ever presented.
- Arithmetic: all comparisons are unsigned on IN_WIDTH+Q_BITS bits. The result |r| ≤ QUARTER_PI always fits WIDTH.

Optional Feature:
- Macro: ANGLE_RANGE_REDUCER_QUADRANT_EN.
- When defined:
  - Adds output port quadrant, signed, Q_BITS+2 bits, carrying the full k.
  - quadrant is registered in ADJUST alongside flip, and resets to 0.
- When undefined: the port and its register are absent, and behaviour is otherwise identical.

Test Plan:
- angle_in=0 → angle_out=0, flip=3'b000, out_valid exactly 9 edges after accept.
- angle_in=8192 (1.0 rad) → angle_out=−4676, flip=3'b101. angle_in=−24576 (−3.0 rad) → angle_out=1160, flip=3'b010.
- Tie boundary:
  - angle_in=6434 → angle_out=6434, flip=3'b000.
  - angle_in=6435 → angle_out=−6433, flip=3'b101.
- Extremes:
  - angle_in=524287 → angle_out=−3301, flip=3'b101 (quadrant=41 with macro).
  - angle_in=−524288 → angle_out=3300, flip=3'b001 (quadrant=−41).
- Backpressure: out_ready=0 for 20 cycles in DONE → outputs stable, in_ready=0, new in_valid ignored. Release → one out handshake, then the next angle is accepted.
- Reset: drop rst_n during DIVIDE cycle 3 → immediately state IDLE, out_valid=0, angle_out=0, flip=0. A new angle after release gives the correct result.

Source files
------------

// File: rtl/angle_range_reducer.sv
// angle_range_reducer: reduces a signed fixed-point angle theta to
// theta = r + k*pi/2 with r in [-pi/4, +pi/4], using a restoring
// shift-subtract divider that produces one quotient bit per cycle.
//
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_ready is high only in IDLE
//   angle_in            signed angle, IN_WIDTH bits, FRAC fractional bits
//   out_valid/out_ready output handshake; out_valid is high only in DONE
//   angle_out           signed residual r, WIDTH bits (Q2.FRAC)
//   flip                quadrant code for the flip/result correction stage
//   quadrant            full signed k (only with ANGLE_RANGE_REDUCER_QUADRANT_EN)
//
// Optional feature macro: ANGLE_RANGE_REDUCER_QUADRANT_EN
module angle_range_reducer #(
  parameter int unsigned IN_WIDTH = 20,
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned FRAC     = 13,
  parameter int unsigned HALF_PI  = 12868
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_WIDTH-1:0]        angle_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic signed [WIDTH-1:0]    angle_out,
  output logic [2:0]                 flip
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
  ,
  output logic signed [IN_WIDTH-FRAC+1:0] quadrant
`endif
);

  localparam int unsigned Q_BITS = IN_WIDTH - FRAC;
  localparam int unsigned AW     = IN_WIDTH + Q_BITS;
  localparam int unsigned MW     = IN_WIDTH + 1;
  localparam int unsigned CW     = (Q_BITS > 1) ? $clog2(Q_BITS) : 1;
  localparam int unsigned KW     = Q_BITS + 2;

  localparam logic [AW-1:0] HP_AW = AW'(HALF_PI);
  localparam logic [AW-1:0] QP_AW = AW'(HALF_PI >> 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, ADJUST, DONE} state_t;

  state_t              state, state_n;
  logic [AW-1:0]       rem, rem_n;
  logic [Q_BITS-1:0]   q, q_n;
  logic                sign, sign_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [WIDTH-1:0]    angle_out_n;
  logic [2:0]          flip_n;

  logic [MW-1:0]       ext, mag;
  logic [AW-1:0]       shifted, rem_a;
  logic                adj;
  logic [Q_BITS-1:0]   q_a;
  logic [WIDTH-1:0]    r_mag, r_c;
  logic [1:0]          k_lo;

  // Magnitude in one extra bit so the most negative input does not overflow
  assign ext = {angle_in[IN_WIDTH-1], angle_in};
  assign mag = angle_in[IN_WIDTH-1] ? (~ext + MW'(1)) : ext;

  // Divisor aligned to the current quotient bit
  assign shifted = HP_AW << cnt;

  // Final rounding step: fold remainders above pi/4 into the next quadrant
  assign adj   = rem > QP_AW;
  assign rem_a = adj ? (rem - HP_AW) : rem;
  assign q_a   = adj ? (q + Q_BITS'(1)) : q;

  // Apply the input sign; only k mod 4 is needed for the flip code
  assign r_mag = rem_a[WIDTH-1:0];
  assign r_c   = sign ? (~r_mag + WIDTH'(1)) : r_mag;
  assign k_lo  = sign ? (~q_a[1:0] + 2'd1) : q_a[1:0];

`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
  logic [KW-1:0] k_full, quadrant_n;
  assign k_full = sign ? (~KW'(q_a) + KW'(1)) : KW'(q_a);
`endif

  // Next-state and datapath update
  always_comb begin
    state_n     = state;
    rem_n       = rem;
    q_n         = q;
    sign_n      = sign;
    cnt_n       = cnt;
    angle_out_n = angle_out;
    flip_n      = flip;
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
    quadrant_n  = quadrant;
`endif
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_n = DIVIDE;
          sign_n  = angle_in[IN_WIDTH-1];
          rem_n   = AW'(mag);
          q_n     = '0;
          cnt_n   = CW'(Q_BITS - 1);
        end
      end
      DIVIDE: begin
        if (rem >= shifted) begin
          rem_n = rem - shifted;
          q_n   = q | (Q_BITS'(1) << cnt);
        end
        if (cnt == '0) begin
          state_n = ADJUST;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      ADJUST: begin
        rem_n       = rem_a;
        q_n         = q_a;
        angle_out_n = r_c;
        case (k_lo)
          2'd0: flip_n = 3'b000;
          2'd1: flip_n = 3'b101;
          2'd2: flip_n = 3'b010;
          2'd3: flip_n = 3'b001;
        endcase
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
        quadrant_n  = k_full;
`endif
        state_n     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rem       <= '0;
      q         <= '0;
      sign      <= 1'b0;
      cnt       <= '0;
      angle_out <= '0;
      flip      <= 3'b000;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
      quadrant  <= '0;
`endif
    end else begin
      state     <= state_n;
      rem       <= rem_n;
      q         <= q_n;
      sign      <= sign_n;
      cnt       <= cnt_n;
      angle_out <= angle_out_n;
      flip      <= flip_n;
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
      quadrant  <= quadrant_n;
`endif
    end
  end

endmodule

// File: tb/tb_angle_range_reducer.sv
// Self-checking bench for angle_range_reducer: directed and random angles
// through a scoreboard, latency, tie boundary, extremes, backpressure and
// mid-operation reset.
module tb_angle_range_reducer;

  localparam int unsigned IN_WIDTH   = 20;
  localparam int unsigned WIDTH      = 16;
  localparam int unsigned FRAC       = 13;
  localparam int unsigned HALF_PI    = 12868;
  localparam int unsigned QUARTER_PI = 6434;
  localparam int unsigned Q_BITS     = IN_WIDTH - FRAC;
  localparam int          BUDGET     = 100;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [IN_WIDTH-1:0]     angle_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [WIDTH-1:0] angle_out;
  logic [2:0]              flip;
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
  logic signed [Q_BITS+1:0] quadrant;
`endif

  typedef struct {
    int r;
    int f;
    int k;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  angle_range_reducer #(
    .IN_WIDTH(IN_WIDTH), .WIDTH(WIDTH), .FRAC(FRAC), .HALF_PI(HALF_PI)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .angle_in(angle_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .angle_out(angle_out), .flip(flip)
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
    , .quadrant(quadrant)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: integer division with round-half-toward-zero on the remainder
  task automatic model(input logic [IN_WIDTH-1:0] a, output exp_t e);
    int th, m, q, rm;
    th = $signed(a);
    m  = (th < 0) ? -th : th;
    q  = m / int'(HALF_PI);
    rm = m % int'(HALF_PI);
    if (rm > int'(QUARTER_PI)) begin
      rm = rm - int'(HALF_PI);
      q  = q + 1;
    end
    if (th < 0) begin
      rm = -rm;
      q  = -q;
    end
    e.r = rm;
    e.k = q;
    case (q & 3)
      0: e.f = 3'b000;
      1: e.f = 3'b101;
      2: e.f = 3'b010;
      default: e.f = 3'b001;
    endcase
  endtask

  task automatic push(input int r, input int f, input int k);
    exp_t e;
    e.r = r; e.f = f; e.k = k;
    sb.push_back(e);
  endtask

  task automatic compare_head(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(0), 32'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_angle_out"}, 32'(angle_out), e.r);
      check({tag, "_flip"}, 32'(flip), e.f);
`ifdef ANGLE_RANGE_REDUCER_QUADRANT_EN
      check({tag, "_quadrant"}, 32'(quadrant), e.k);
`endif
    end
  endtask

  // Ends on the falling edge right after the accepting rising edge
  task automatic send(input logic [IN_WIDTH-1:0] a);
    int n = 0;
    @(negedge clk);
    angle_in = a;
    in_valid = 1'b1;
    while (!in_ready && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) check("send_timeout", 32'(in_ready), 32'(1));
    @(negedge clk);
    in_valid = 1'b0;
    angle_in = IN_WIDTH'($urandom);
  endtask

  // Must start on the falling edge right after the accepting edge
  task automatic recv(input string tag);
    int n = 0;
    out_ready = 1'b1;
    while (!out_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) begin
      check({tag, "_out_timeout"}, 32'(out_valid), 32'(1));
    end else begin
      // Rising edges counted from the handshake edge itself
      check({tag, "_latency"}, 32'(n + 1), 32'(Q_BITS + 2));
      compare_head(tag);
    end
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(out_valid), 32'(0));
  endtask

  task automatic run(input string tag, input logic [IN_WIDTH-1:0] a,
                     input int r, input int f, input int k);
    push(r, f, k);
    send(a);
    recv(tag);
  endtask

  initial begin
    exp_t e;
    logic [IN_WIDTH-1:0] a;
    int n;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_angle_out", 32'(angle_out), 32'(0));
    check("rst_flip", 32'(flip), 32'(0));
    rst_n = 1'b1;

    // Directed cases
    run("zero",     20'd0,               0,     3'b000,   0);
    run("one_rad",  20'd8192,           -4676,  3'b101,   1);
    run("m3_rad",   IN_WIDTH'(-24576),   1160,  3'b010,  -2);
    run("tie",      20'd6434,            6434,  3'b000,   0);
    run("tie_p1",   20'd6435,           -6433,  3'b101,   1);
    run("max_pos",  20'd524287,         -3301,  3'b101,  41);
    run("max_neg",  IN_WIDTH'(-524288),  3300,  3'b001, -41);

    // Random angles against the reference model
    for (int i = 0; i < 6; i++) begin
      a = IN_WIDTH'($urandom);
      model(a, e);
      run("rand", a, e.r, e.f, e.k);
    end

    // Backpressure: hold DONE for 20 cycles with a competing input pending
    model(20'd8192, e);
    push(e.r, e.f, e.k);
    send(20'd8192);
    n = 0;
    while (!out_valid && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("bp_reach_done", 32'(out_valid), 32'(1));
    compare_head("bp_first");
    a = IN_WIDTH'(-24576);
    angle_in = a;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("bp_hold_angle", 32'(angle_out), e.r);
      check("bp_hold_flip", 32'(flip), e.f);
      check("bp_in_ready", 32'(in_ready), 32'(0));
      check("bp_out_valid", 32'(out_valid), 32'(1));
    end
    push(1160, 3'b010, -2);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", 32'(out_valid), 32'(0));
    check("bp_release_ready", 32'(in_ready), 32'(1));
    check("bp_release_keep", 32'(angle_out), e.r);
    @(negedge clk);
    in_valid = 1'b0;
    recv("bp_second");

    // Reset during the third DIVIDE cycle aborts the operation
    send(20'd8192);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'(1));
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_angle_out", 32'(angle_out), 32'(0));
    check("abort_flip", 32'(flip), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst", 20'd6435, -6433, 3'b101, 1);

    check("sb_drained", 32'(sb.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
